// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags, sticky error flags and flush.
// Define FIFO_FWFT_EN for first-word fall-through read data; otherwise reads have one cycle of latency.
// The read-data port is called dout because `do` is a reserved word in SystemVerilog.
module sync_fifo_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [DATA_W-1:0] di,
    input  logic              re,
    output logic [DATA_W-1:0] dout,
    output logic              empty_flag,
    output logic              full_flag,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
    localparam logic             AF_RST  = (AF_LEVEL == 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_acc;
    logic              wr_acc;
    logic              rd_en;
    logic              wr_en;
    logic [CNT_W-1:0]  count_nxt;

    // A write into a full FIFO is only accepted when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc = re & ~empty_flag;
        wr_acc = we & (~full_flag | rd_acc);
        rd_en  = rd_acc & ~clr;
        wr_en  = wr_acc & ~clr;
    end

    // Next occupancy; flush wins over any transfer.
    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Storage array is not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= di;
        end
    end

    // Pointers, count, flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty_flag   <= 1'b1;
            full_flag    <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= AF_RST;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_nxt;
            empty_flag   <= (count_nxt == '0);
            full_flag    <= (count_nxt == DEPTH_C);
            almost_empty <= (count_nxt <= AE_C);
            almost_full  <= (count_nxt >= AF_C);
            if (clr) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
                if (we && full_flag && !rd_acc) begin
                    overflow <= 1'b1;
                end
                if (re && empty_flag) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is always visible; re consumes it at the edge.
    assign dout = mem[rd_ptr];
`else
    // Registered read; holds when idle and across a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (rd_en) begin
            dout <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=16, AF=12, AE=2).
// Read checks adapt to FIFO_FWFT_EN when it is defined for the build.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       we  = 1'b0;
    logic [7:0] di  = 8'h00;
    logic       re  = 1'b0;
    logic [7:0] dout;
    logic       empty_flag, full_flag, almost_empty, almost_full;
    logic [4:0] count;
    logic       overflow, underflow;

    int vectors = 0;
    int miscompares = 0;

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .di(di), .re(re), .dout(dout),
        .empty_flag(empty_flag), .full_flag(full_flag),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops one word and returns what the FIFO presented for it.
    task automatic do_read(output logic [7:0] d);
`ifdef FIFO_FWFT_EN
        d  = dout;
        re = 1'b1;
        tick();
        re = 1'b0;
`else
        re = 1'b1;
        tick();
        re = 1'b0;
        d  = dout;
`endif
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            we = 1'b1;
            di = base + 8'(i);
            tick();
        end
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if ({empty_flag, almost_empty, full_flag, almost_full, overflow, underflow} !== 6'b110000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b want=110000",
                     {empty_flag, almost_empty, full_flag, almost_full, overflow, underflow});
        end
        vectors++;
        if (count !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_count got=%0d want=0", count);
        end
`ifndef FIFO_FWFT_EN
        vectors++;
        if (dout !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_dout got=%h want=00", dout);
        end
`endif
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 16; i++) begin
            we = 1'b1;
            di = 8'(i);
            tick();
            vectors++;
            if (count !== 5'(i) || almost_full !== (i >= 12)) begin
                miscompares++;
                $display("FAIL fill_%0d count=%0d af=%b want count=%0d af=%b",
                         i, count, almost_full, i, (i >= 12));
            end
        end
        di = 8'hEE;
        tick();
        we = 1'b0;
        vectors++;
        if (count !== 5'd16 || full_flag !== 1'b1 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow count=%0d full=%b ovf=%b want 16/1/1", count, full_flag, overflow);
        end
    endtask

    task automatic test_drain_underflow();
        logic [7:0] d;
        for (int i = 1; i <= 16; i++) begin
            do_read(d);
            vectors++;
            if (d !== 8'(i) || count !== 5'(16 - i)) begin
                miscompares++;
                $display("FAIL drain_%0d data=%h count=%0d want data=%h count=%0d",
                         i, d, count, 8'(i), 16 - i);
            end
        end
        vectors++;
        if (empty_flag !== 1'b1 || almost_empty !== 1'b1 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL drained empty=%b ae=%b unf=%b want 1/1/0", empty_flag, almost_empty, underflow);
        end
        re = 1'b1;
        tick();
        re = 1'b0;
        vectors++;
        if (underflow !== 1'b1 || overflow !== 1'b1 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL underflow unf=%b ovf=%b count=%0d want 1/1/0", underflow, overflow, count);
        end
`ifndef FIFO_FWFT_EN
        vectors++;
        if (dout !== 8'h10) begin
            miscompares++;
            $display("FAIL empty_read_hold dout=%h want=10", dout);
        end
`endif
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++;
        if (overflow !== 1'b0 || underflow !== 1'b0 || empty_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_errors ovf=%b unf=%b empty=%b want 0/0/1", overflow, underflow, empty_flag);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] d;
        fill(16, 8'h01);
        we = 1'b1;
        re = 1'b1;
        di = 8'hAA;
`ifdef FIFO_FWFT_EN
        d = dout;
`endif
        tick();
        we = 1'b0;
        re = 1'b0;
`ifndef FIFO_FWFT_EN
        d = dout;
`endif
        vectors++;
        if (d !== 8'h01 || count !== 5'd16 || full_flag !== 1'b1 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL full_rw data=%h count=%0d full=%b ovf=%b want 01/16/1/0",
                     d, count, full_flag, overflow);
        end
        for (int i = 2; i <= 17; i++) begin
            do_read(d);
            vectors++;
            if (d !== ((i == 17) ? 8'hAA : 8'(i))) begin
                miscompares++;
                $display("FAIL full_rw_drain_%0d data=%h want=%h", i, d, (i == 17) ? 8'hAA : 8'(i));
            end
        end
        vectors++;
        if (empty_flag !== 1'b1 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL full_rw_empty empty=%b count=%0d want 1/0", empty_flag, count);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] d;
        logic [7:0] exp;
        for (int i = 0; i < 20; i++) begin
            we = 1'b1;
            di = 8'h40 + 8'(i);
            re = (i >= 3);
            d  = dout;
            tick();
`ifndef FIFO_FWFT_EN
            d = dout;
`endif
            q.push_back(8'h40 + 8'(i));
            if (i >= 3) begin
                exp = q.pop_front();
                vectors++;
                if (d !== exp) begin
                    miscompares++;
                    $display("FAIL wrap_%0d data=%h want=%h", i, d, exp);
                end
            end
            vectors++;
            if (count !== 5'(q.size()) || count > 5'd16) begin
                miscompares++;
                $display("FAIL wrap_count_%0d count=%0d want=%0d", i, count, q.size());
            end
        end
        we = 1'b0;
        re = 1'b0;
        while (q.size() > 0) begin
            exp = q.pop_front();
            do_read(d);
            vectors++;
            if (d !== exp) begin
                miscompares++;
                $display("FAIL wrap_tail data=%h want=%h", d, exp);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] d;
        fill(5, 8'h60);
        we = 1'b1;
        di = 8'h99;
        re = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (count !== 5'd0 || empty_flag !== 1'b1 || almost_empty !== 1'b1 || full_flag !== 1'b0 ||
            almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset count=%0d empty=%b ae=%b full=%b af=%b ovf=%b unf=%b",
                     count, empty_flag, almost_empty, full_flag, almost_full, overflow, underflow);
        end
`ifndef FIFO_FWFT_EN
        vectors++;
        if (dout !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset_dout got=%h want=00", dout);
        end
`endif
        we = 1'b0;
        re = 1'b0;
        tick();
        rst = 1'b0;
        we = 1'b1;
        di = 8'h77;
        tick();
        we = 1'b0;
        vectors++;
        if (count !== 5'd1) begin
            miscompares++;
            $display("FAIL post_reset_write count=%0d want=1", count);
        end
        do_read(d);
        vectors++;
        if (d !== 8'h77 || empty_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_read data=%h empty=%b want 77/1", d, empty_flag);
        end
    endtask

    task automatic test_empty_rw();
        we = 1'b1;
        re = 1'b1;
        di = 8'h5A;
        tick();
        we = 1'b0;
        re = 1'b0;
        vectors++;
        if (count !== 5'd1 || empty_flag !== 1'b0 || underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_rw count=%0d empty=%b unf=%b want 1/0/1", count, empty_flag, underflow);
        end
`ifdef FIFO_FWFT_EN
        vectors++;
        if (dout !== 8'h5A) begin
            miscompares++;
            $display("FAIL fwft_head dout=%h want=5A", dout);
        end
`endif
        re = 1'b1;
        tick();
        re = 1'b0;
        vectors++;
        if (empty_flag !== 1'b1 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL empty_rw_pop empty=%b count=%0d want 1/0", empty_flag, count);
        end
    endtask

    task automatic test_clr();
        fill(5, 8'h20);
        vectors++;
        if (count !== 5'd5 || almost_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_pre count=%0d ae=%b want 5/0", count, almost_empty);
        end
        clr = 1'b1;
        we  = 1'b1;
        re  = 1'b1;
        tick();
        clr = 1'b0;
        we  = 1'b0;
        re  = 1'b0;
        vectors++;
        if (count !== 5'd0 || empty_flag !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL clr count=%0d empty=%b ovf=%b unf=%b want 0/1/0/0",
                     count, empty_flag, overflow, underflow);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_full_rw();
        test_wrap();
        test_reset_midstream();
        test_empty_rw();
        test_clr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
